pool_layer_stream: RTL

- Parametrised 2x2, stride-2 pooling stage for the cnn_core datapath. Successor to the fixed 6x6 single-channel average pool.
- Consumes a raster-order feature-map stream (one pixel position per beat, all channels in parallel) and emits pooled pixels as a stream.
- Mode is run-time selectable per frame: average or max. Sits between a conv layer's output stream and the next layer or FC input.
- Stores only one half-row of partial results per channel; never needs the whole frame.

---
 rtl/pool_pkg.sv | 20 ++
 rtl/pool_layer_stream_lane.sv | 55 +++++
 rtl/pool_layer_stream.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pool_pkg.sv
// Shared definitions for the 2x2 stride-2 pooling stage: mode codes, FSM
// state encoding and the accumulator width used by the per-channel lanes.
package pool_pkg;

  localparam logic POOL_AVG = 1'b0;
  localparam logic POOL_MAX = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } pool_state_e;

  // Two guard bits hold the sum of four signed pixels without overflow.
  function automatic int ACC_W(input int data_w);
    return data_w + 2;
  endfunction

endpackage

// File: rtl/pool_layer_stream_lane.sv
// One channel of the pooling datapath: half-row partial buffer, hold register
// for the odd-row running value, combine and final shift/select.
module pool_lane
  import pool_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NWIN   = 3,
  parameter int WIN_W  = 2
) (
  input  logic                     clk,
  input  logic                     max_mode_i,
  input  logic                     wr_en_i,
  input  logic                     row_odd_i,
  input  logic                     col_odd_i,
  input  logic [WIN_W-1:0]         win_i,
  input  logic signed [DATA_W-1:0] pix_i,
  output logic signed [DATA_W-1:0] result_o
);

  localparam int AW = ACC_W(DATA_W);

  logic signed [AW-1:0] part_q [NWIN];
  logic signed [AW-1:0] hold_q;
  logic signed [AW-1:0] pix_ext;
  logic signed [AW-1:0] lhs;
  logic signed [AW-1:0] comb;
  logic signed [AW-1:0] avg_shift;

  always_comb begin
    pix_ext = AW'(pix_i);
    // The closing pixel of a window combines with the hold value; every other
    // combine works against the column pair's partial entry.
    lhs = (row_odd_i && col_odd_i) ? hold_q : part_q[win_i];
    if (max_mode_i) begin
      comb = (pix_ext > lhs) ? pix_ext : lhs;
    end else begin
      comb = lhs + pix_ext;
    end
    avg_shift = comb >>> 2;
    result_o  = max_mode_i ? comb[DATA_W-1:0] : avg_shift[DATA_W-1:0];
  end

  // Partial entries need no reset: the even-row, even-column beat always
  // writes an entry before anything reads it.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      if (!row_odd_i) begin
        part_q[win_i] <= col_odd_i ? comb : pix_ext;
      end else if (!col_odd_i) begin
        hold_q <= comb;
      end
    end
  end

endmodule

// File: rtl/pool_layer_stream.sv
// 2x2 stride-2 average/max pooling over a raster-order feature-map stream.
// Handshake: a beat moves on either port exactly in a cycle where valid && ready.
module pool_layer_stream
  import pool_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int CHANNELS = 1,
  parameter int FM_W     = 6,
  parameter int FM_H     = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         mode,
  input  logic [CHANNELS*DATA_W-1:0]   in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [CHANNELS*DATA_W-1:0]   out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy,
  output logic                         done,
  output logic [1:0]                   dbg_state
);

  localparam int  NWIN   = FM_W / 2;
  localparam int  WIN_W  = (NWIN > 1) ? $clog2(NWIN) : 1;
  localparam int  CW     = $clog2(FM_W);
  localparam int  RW     = $clog2(FM_H);
  localparam bit  ODD_W  = (FM_W % 2) != 0;
  localparam bit  ODD_H  = (FM_H % 2) != 0;

  pool_state_e                state_q;
  logic [CW-1:0]              col_q;
  logic [RW-1:0]              row_q;
  logic                       mode_q;
  logic                       out_valid_q;
  logic [CHANNELS*DATA_W-1:0] out_data_q;
  logic [CHANNELS*DATA_W-1:0] result_d;

  logic             accept;
  logic             last_col;
  logic             last_row;
  logic             discard;
  logic             win_done;
  logic [WIN_W-1:0] win;

  assign in_ready  = (state_q == ST_RUN) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign last_col  = (col_q == CW'(FM_W - 1));
  assign last_row  = (row_q == RW'(FM_H - 1));
  // A trailing odd column/row has no partner; its beats are consumed unused.
  assign discard   = (ODD_W && last_col) || (ODD_H && last_row);
  assign win_done  = accept && !discard && row_q[0] && col_q[0];
  assign win       = WIN_W'(col_q >> 1);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    pool_lane #(
      .DATA_W (DATA_W),
      .NWIN   (NWIN),
      .WIN_W  (WIN_W)
    ) u_lane (
      .clk        (clk),
      .max_mode_i (mode_q == POOL_MAX),
      .wr_en_i    (accept && !discard),
      .row_odd_i  (row_q[0]),
      .col_odd_i  (col_q[0]),
      .win_i      (win),
      .pix_i      (in_data[c*DATA_W +: DATA_W]),
      .result_o   (result_d[c*DATA_W +: DATA_W])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      mode_q      <= POOL_AVG;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      // win_done implies the slot is free or draining this cycle.
      if (win_done) begin
        out_valid_q <= 1'b1;
        out_data_q  <= result_d;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mode_q  <= mode;
            col_q   <= '0;
            row_q   <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept) begin
            if (last_col) begin
              col_q <= '0;
              row_q <= last_row ? '0 : row_q + RW'(1);
            end else begin
              col_q <= col_q + CW'(1);
            end
            if (last_col && last_row) begin
              state_q <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          if (!out_valid_q || out_ready) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign dbg_state = state_q;

endmodule
